xmodem_imem_loader: RTL and testbench

//  Debug-unit controller that receives a program over UART (XMODEM, 128-byte blocks, 8-bit checksum).

---
 rtl/xmodem_pkg.sv | 28 ++
 rtl/xmodem_word_packer.sv | 93 +++++++++
 rtl/xmodem_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_xmodem_imem_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmodem_pkg.sv
// Shared constants and state encoding for the XMODEM instruction-memory loader.
//   - XMODEM control bytes (SOH, EOT, ACK, NAK, CAN)
//   - block payload size and the width of a byte index inside a block
//   - loader FSM state encoding
package xmodem_pkg;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CAN = 8'h18;

  localparam int BLOCK_BYTES = 128;
  localparam int NB_BYTE_IDX = $clog2(BLOCK_BYTES);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_SOH = 4'd1,
    ST_BLK      = 4'd2,
    ST_BLKN     = 4'd3,
    ST_DATA     = 4'd4,
    ST_CKSUM    = 4'd5,
    ST_RESP     = 4'd6,
    ST_DONE     = 4'd7,
    ST_ABORT    = 4'd8
  } state_t;

endpackage

// File: rtl/xmodem_word_packer.sv
// Payload datapath of one XMODEM block.
//   Counts payload bytes, accumulates the 8-bit checksum and packs bytes
//   little-endian into imem words. When the last byte of a word arrives the
//   word is written one cycle later, provided writes are enabled for this
//   block and the word address lies inside imem.
// Ports
//   clk, rst_n       clock, async active-low reset
//   clear            restart at byte 0 with checksum 0 (new block header)
//   byte_valid       byte_data is a payload byte consumed this cycle
//   byte_data        payload byte
//   write_en         block is new (not a duplicate, header intact)
//   base_addr        imem byte address of payload byte 0
//   checksum         sum of payload bytes so far, mod 256
//   last_byte        byte_valid for the final payload byte of the block
//   imem_we          one-cycle imem write strobe
//   imem_addr        word-aligned imem byte address
//   imem_wdata       assembled word, payload byte 0 of the word in [7:0]
module xmodem_word_packer
  import xmodem_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int ADDR_W  = 7,
  parameter int NB_BASE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [NB_DATA-1:0] byte_data,
  input  logic               write_en,
  input  logic [NB_BASE-1:0] base_addr,
  output logic [NB_DATA-1:0] checksum,
  output logic               last_byte,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [NB_WORD-1:0] imem_wdata
);

  localparam int BPW    = NB_WORD / NB_DATA;
  localparam int LANE_W = $clog2(BPW);

  logic [NB_BYTE_IDX-1:0] idx_q;
  logic [NB_DATA-1:0]     sum_q;
  logic [NB_WORD-1:0]     word_q;
  logic [NB_WORD-1:0]     word_next;
  logic [LANE_W-1:0]      lane;
  logic                   word_full;
  logic [NB_BASE-1:0]     word_addr;
  logic                   in_range;

  assign lane      = idx_q[LANE_W-1:0];
  assign word_full = byte_valid && (lane == LANE_W'(BPW - 1));
  // Address of the word's first byte: base plus the index with lane bits cleared.
  assign word_addr = base_addr + NB_BASE'({idx_q[NB_BYTE_IDX-1:LANE_W], {LANE_W{1'b0}}});
  // Anything above the imem capacity is silently dropped.
  assign in_range  = (word_addr >> ADDR_W) == '0;
  assign checksum  = sum_q;
  assign last_byte = byte_valid && (idx_q == NB_BYTE_IDX'(BLOCK_BYTES - 1));

  always_comb begin
    word_next = word_q;
    word_next[lane*NB_DATA +: NB_DATA] = byte_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (clear) begin
        idx_q  <= '0;
        sum_q  <= '0;
        word_q <= '0;
      end else if (byte_valid) begin
        idx_q  <= idx_q + 1'b1;
        sum_q  <= sum_q + byte_data;
        word_q <= word_next;
        if (word_full && write_en && in_range) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_addr[ADDR_W-1:0];
          imem_wdata <= word_next;
        end
      end
    end
  end

endmodule

// File: rtl/xmodem_imem_loader.sv
// XMODEM (128-byte blocks, 8-bit checksum) program loader for CPU imem.
//   Pops bytes from the UART RX FIFO, writes payload words to imem through
//   xmodem_word_packer and answers every block on the UART TX path with
//   ACK / NAK / CAN. The CPU is gated off while a load is in progress.
// Ports
//   clk, i_rst_n     clock, async active-low reset
//   i_start          pulse: arm the loader (ignored while busy)
//   i_rx_empty       RX FIFO empty
//   i_rx_data        RX FIFO head byte (first-word fall-through)
//   o_rx_rd          RX FIFO pop
//   o_tx_wr          push o_tx_wdata into TX FIFO
//   o_tx_wdata       response byte
//   o_tx_start       TX start, one cycle after o_tx_wr
//   o_imem_we        imem write strobe
//   o_imem_addr      imem byte address (word aligned)
//   o_imem_wdata     imem write word
//   o_cpu_en         CPU enable (only when idle after a completed load)
//   o_busy           loader active
//   o_done           sticky: EOT received and ACKed
//   o_error          sticky: transfer aborted
//   o_dbg_state      current FSM state (xmodem_pkg::state_t encoding)
//
// RX handshake: a byte is transferred in every cycle where !i_rx_empty and
// o_rx_rd are both high at the rising clock edge; o_rx_rd is never raised
// while i_rx_empty is high, so at most one byte is consumed per cycle.
module xmodem_imem_loader
  import xmodem_pkg::*;
#(
  parameter int NB_UART_DATA    = 8,
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 7,
  parameter int NB_TIMEOUT      = 24,
  parameter int TIMEOUT_CYCLES  = 10000000,
  parameter int MAX_RETRY       = 10
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_rx_empty,
  input  logic [NB_UART_DATA-1:0]    i_rx_data,
  output logic                       o_rx_rd,
  output logic                       o_tx_wr,
  output logic [NB_UART_DATA-1:0]    o_tx_wdata,
  output logic                       o_tx_start,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_cpu_en,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [3:0]                 o_dbg_state
);

  // The base must reach past the imem window so out-of-range blocks are
  // recognised; its top bit saturates once set.
  localparam int NB_BASE  = ((IMEM_ADDR_WIDTH > 15) ? IMEM_ADDR_WIDTH : 15) + 1;
  localparam int NB_RETRY = $clog2(MAX_RETRY + 1);
  localparam logic [NB_TIMEOUT-1:0] TO_LIM = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [NB_UART_DATA-1:0] blk_q, blk_d;
  logic                    hdr_bad_q, hdr_bad_d;
  logic                    blk_new_q, blk_new_d;
  logic                    cks_ok_q, cks_ok_d;
  logic [NB_UART_DATA-1:0] expected_q, expected_d;
  logic [NB_BASE-1:0]      base_q, base_d;
  logic [NB_RETRY-1:0]     retry_q, retry_d, retry_inc;
  logic                    retry_hit;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [NB_TIMEOUT-1:0]   timer_q;
  logic                    timeout;

  logic                    rx_active;
  logic                    pop;
  logic                    tx_req;
  logic [NB_UART_DATA-1:0] tx_byte;
  logic                    nak_event;
  logic                    hdr_ok;
  logic                    pk_clear;
  logic                    pk_valid;
  logic                    pk_last;
  logic [NB_UART_DATA-1:0] pk_sum;

  assign rx_active = (state_q == ST_WAIT_SOH) || (state_q == ST_BLK) || (state_q == ST_BLKN) ||
                     (state_q == ST_DATA) || (state_q == ST_CKSUM);
  assign pop       = rx_active && !i_rx_empty;
  assign o_rx_rd   = pop;
  assign timeout   = timer_q >= TO_LIM;
  assign retry_inc = retry_q + 1'b1;
  assign retry_hit = retry_inc >= NB_RETRY'(MAX_RETRY);
  assign hdr_ok    = (blk_q ^ i_rx_data) == '1;
  assign pk_valid  = pop && (state_q == ST_DATA);

  assign o_busy      = state_q != ST_IDLE;
  assign o_cpu_en    = (state_q == ST_IDLE) && done_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_dbg_state = state_q;

  xmodem_word_packer #(
    .NB_DATA (NB_UART_DATA),
    .NB_WORD (NB_INSTRUCTION),
    .ADDR_W  (IMEM_ADDR_WIDTH),
    .NB_BASE (NB_BASE)
  ) u_packer (
    .clk        (clk),
    .rst_n      (i_rst_n),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (i_rx_data),
    .write_en   (blk_new_q),
    .base_addr  (base_q),
    .checksum   (pk_sum),
    .last_byte  (pk_last),
    .imem_we    (o_imem_we),
    .imem_addr  (o_imem_addr),
    .imem_wdata (o_imem_wdata)
  );

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    hdr_bad_d  = hdr_bad_q;
    blk_new_d  = blk_new_q;
    cks_ok_d   = cks_ok_q;
    expected_d = expected_q;
    base_d     = base_q;
    retry_d    = retry_q;
    done_d     = done_q;
    error_d    = error_q;
    tx_req     = 1'b0;
    tx_byte    = NAK;
    pk_clear   = 1'b0;
    nak_event  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          expected_d = 8'd1;
          base_d     = '0;
          retry_d    = '0;
          tx_req     = 1'b1;
          tx_byte    = NAK;
          state_d    = ST_WAIT_SOH;
        end
      end
      ST_WAIT_SOH: begin
        if (pop) begin
          case (i_rx_data)
            SOH: begin
              pk_clear = 1'b1;
              state_d  = ST_BLK;
            end
            EOT: begin
              tx_req  = 1'b1;
              tx_byte = ACK;
              state_d = ST_DONE;
            end
            CAN:     state_d = ST_ABORT;
            default: state_d = ST_WAIT_SOH;
          endcase
        end else if (timeout) begin
          nak_event = 1'b1;
        end
      end
      ST_BLK: begin
        if (pop) begin
          blk_d   = i_rx_data;
          state_d = ST_BLKN;
        end else if (timeout) begin
          nak_event = 1'b1;
        end
      end
      ST_BLKN: begin
        if (pop) begin
          // A corrupted header is only NAKed; the sequence check applies
          // once the block number is known to be intact.
          hdr_bad_d = !hdr_ok;
          blk_new_d = hdr_ok && (blk_q == expected_q);
          if (hdr_ok && (blk_q != expected_q) && (blk_q != expected_q - 8'd1)) begin
            state_d = ST_ABORT;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout) begin
          nak_event = 1'b1;
        end
      end
      ST_DATA: begin
        if (pop) begin
          if (pk_last) state_d = ST_CKSUM;
        end else if (timeout) begin
          nak_event = 1'b1;
        end
      end
      ST_CKSUM: begin
        if (pop) begin
          cks_ok_d = i_rx_data == pk_sum;
          state_d  = ST_RESP;
        end else if (timeout) begin
          nak_event = 1'b1;
        end
      end
      ST_RESP: begin
        if (!hdr_bad_q && cks_ok_q) begin
          tx_req  = 1'b1;
          tx_byte = ACK;
          state_d = ST_WAIT_SOH;
          if (blk_new_q) begin
            base_d     = base_q[NB_BASE-1] ? base_q : base_q + NB_BASE'(BLOCK_BYTES);
            expected_d = expected_q + 8'd1;
            retry_d    = '0;
          end
        end else begin
          nak_event = 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        tx_req  = 1'b1;
        tx_byte = CAN;
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared retry path for timeouts and bad blocks.
    if (nak_event) begin
      retry_d = retry_inc;
      if (retry_hit) begin
        state_d = ST_ABORT;
      end else begin
        tx_req  = 1'b1;
        tx_byte = NAK;
        state_d = ST_WAIT_SOH;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      blk_q      <= '0;
      hdr_bad_q  <= 1'b0;
      blk_new_q  <= 1'b0;
      cks_ok_q   <= 1'b0;
      expected_q <= 8'd1;
      base_q     <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      hdr_bad_q  <= hdr_bad_d;
      blk_new_q  <= blk_new_d;
      cks_ok_q   <= cks_ok_d;
      expected_q <= expected_d;
      base_q     <= base_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Idle-time counter: cleared by any RX byte or TX response, saturating.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else if ((state_q == ST_IDLE) || pop || tx_req) begin
      timer_q <= '0;
    end else if (timer_q != '1) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // TX sequencing: byte pushed in cycle N, start strobe in cycle N+1.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_wr    <= 1'b0;
      o_tx_wdata <= '0;
      o_tx_start <= 1'b0;
    end else begin
      o_tx_wr    <= tx_req;
      o_tx_start <= o_tx_wr;
      if (tx_req) o_tx_wdata <= tx_byte;
    end
  end

endmodule

// File: tb/tb_xmodem_imem_loader.sv
// Bench for xmodem_imem_loader: RX FIFO model, TX and imem monitors, and a
// reference of the host/loader protocol that predicts response bytes and
// imem contents from the XMODEM rules.
module tb_xmodem_imem_loader;

  localparam int TO   = 300;
  localparam int MAXR = 10;
  localparam logic [7:0] B_SOH = 8'h01;
  localparam logic [7:0] B_EOT = 8'h04;
  localparam logic [7:0] B_ACK = 8'h06;
  localparam logic [7:0] B_NAK = 8'h15;
  localparam logic [7:0] B_CAN = 8'h18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        o_rx_rd, o_tx_wr, o_tx_start, o_imem_we;
  logic [7:0]  o_tx_wdata;
  logic [6:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_en, o_busy, o_done, o_error;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  xmodem_imem_loader #(
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_rx_empty   (rx_empty),
    .i_rx_data    (rx_data),
    .o_rx_rd      (o_rx_rd),
    .o_tx_wr      (o_tx_wr),
    .o_tx_wdata   (o_tx_wdata),
    .o_tx_start   (o_tx_start),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_en     (o_cpu_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_dbg_state  (dbg_state)
  );

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          tx_cyc[$];
  logic [31:0] tb_imem[32];
  logic [7:0]  ref_mem[128];
  logic [7:0]  blk_data[128];
  logic [7:0]  s1_data[128];
  int          wr_cnt = 0;
  logic [6:0]  first_wr_addr = '0;
  logic        prev_wr = 1'b0;

  // reference protocol state
  logic [7:0]  ref_expected = 8'd1;
  int          ref_base = 0;
  int          ref_retry = 0;
  logic        ref_done = 1'b0;
  logic        ref_error = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // clock/reset-side helpers
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // RX FIFO model: pop on the edge where o_rx_rd is seen, present the new head just after.
  always @(posedge clk) begin
    if (o_rx_rd === 1'b1) begin
      if (rx_q.size() == 0) check("rx_pop_when_empty", 32'(rx_q.size()), 32'd1);
      else rx_q.pop_front();
    end
    #1;
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  // TX scoreboard and imem monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_tx_start === 1'b1 || prev_wr) check("tx_start_after_wr", 32'(o_tx_start), 32'(prev_wr));
    prev_wr = (o_tx_wr === 1'b1);
    if (o_tx_wr === 1'b1) begin
      tx_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("tx_unexpected", 32'(o_tx_wdata), 32'h100);
      else check("tx_byte", 32'(o_tx_wdata), 32'(exp_q.pop_front()));
    end
    if (o_imem_we === 1'b1) begin
      check("imem_addr_align", 32'(o_imem_addr[1:0]), 32'd0);
      if (wr_cnt == 0) first_wr_addr = o_imem_addr;
      wr_cnt++;
      tb_imem[o_imem_addr[6:2]] = o_imem_wdata;
    end
  end

  // driver tasks and protocol reference
  task automatic ref_nak();
    ref_retry++;
    if (ref_retry >= MAXR) begin
      exp_q.push_back(B_CAN);
      ref_error = 1'b1;
    end else begin
      exp_q.push_back(B_NAK);
    end
  endtask

  task automatic do_start();
    ref_expected = 8'd1;
    ref_base     = 0;
    ref_retry    = 0;
    ref_done     = 1'b0;
    ref_error    = 1'b0;
    exp_q.push_back(B_NAK);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Host sends one block from blk_data: header, n_data payload bytes and,
  // for a full block, the checksum plus cks_delta. Returns expected writes.
  task automatic host_block(input logic [7:0] blk, input logic [7:0] blkn,
                            input logic [7:0] cks_delta, input int n_data, output int exp_wr);
    logic [7:0] sum;
    logic       hdr_ok, is_new, abort;
    sum = 8'h00;
    for (int i = 0; i < 128; i++) sum = sum + blk_data[i];
    hdr_ok = (blk ^ blkn) == 8'hFF;
    abort  = hdr_ok && (blk != ref_expected) && (blk != ref_expected - 8'd1);
    exp_wr = 0;
    if (abort) begin
      exp_q.push_back(B_CAN);
      ref_error = 1'b1;
    end else begin
      is_new = hdr_ok && (blk == ref_expected);
      if (is_new) begin
        for (int i = 0; i < (n_data / 4) * 4; i++)
          if (ref_base + i < 128) ref_mem[ref_base + i] = blk_data[i];
        if (ref_base < 128) exp_wr = n_data / 4;
      end
      if (n_data == 128 && hdr_ok && cks_delta == 8'h00) begin
        exp_q.push_back(B_ACK);
        if (is_new) begin
          ref_base     = ref_base + 128;
          ref_expected = ref_expected + 8'd1;
          ref_retry    = 0;
        end
      end else begin
        ref_nak();
      end
    end
    rx_q.push_back(B_SOH);
    rx_q.push_back(blk);
    rx_q.push_back(blkn);
    if (!abort) begin
      for (int i = 0; i < n_data; i++) rx_q.push_back(blk_data[i]);
      if (n_data == 128) rx_q.push_back(sum + cks_delta);
    end
  endtask

  task automatic host_eot();
    exp_q.push_back(B_ACK);
    ref_done = 1'b1;
    rx_q.push_back(B_EOT);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_tx_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) step();
  endtask

  task automatic run_block(input string tag, input logic [7:0] blk, input logic [7:0] blkn,
                           input logic [7:0] cks_delta, input int n_data, input int budget);
    int w;
    wr_cnt = 0;
    host_block(blk, blkn, cks_delta, n_data, w);
    drain(tag, budget);
    check({tag, "_writes"}, 32'(wr_cnt), 32'(w));
  endtask

  task automatic check_status(input string tag);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'(ref_done));
    check({tag, "_error"}, 32'(o_error), 32'(ref_error));
    check({tag, "_cpu_en"}, 32'(o_cpu_en), 32'(ref_done));
  endtask

  task automatic check_imem(input string tag);
    for (int i = 0; i < 32; i++)
      check(tag, tb_imem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
  endtask

  task automatic rand_data();
    for (int i = 0; i < 128; i++) blk_data[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          span;
    for (int i = 0; i < 32; i++) tb_imem[i] = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;

    // reset state, with bytes waiting in the FIFO
    rx_q.push_back(8'h55);
    repeat (4) step();
    check("rst_outputs", {o_rx_rd, o_tx_wr, o_tx_start, o_imem_we, o_cpu_en, o_busy, o_done, o_error}, 32'd0);
    check("rst_tx_wdata", 32'(o_tx_wdata), 32'd0);
    check("rst_imem_addr", 32'(o_imem_addr), 32'd0);
    check("rst_imem_wdata", o_imem_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_no_pop", 32'(rx_q.size()), 32'd1);
    rx_q.delete();
    step();

    // scenario 1: one program block then EOT
    for (int i = 0; i < 20; i++) begin
      w = $urandom();
      if (i == 0)  w = 32'h00108093;
      if (i == 19) w = 32'h00F12523;
      for (int b = 0; b < 4; b++) blk_data[4*i+b] = w[8*b +: 8];
    end
    for (int i = 80; i < 128; i++) blk_data[i] = 8'h1A;
    s1_data = blk_data;
    do_start();
    check("s1_busy", 32'(o_busy), 32'd1);
    check("s1_cpu_en_held", 32'(o_cpu_en), 32'd0);
    drain("s1_nak", 50);
    run_block("s1_blk1", 8'h01, 8'hFE, 8'h00, 128, 400);
    host_eot();
    drain("s1_eot", 50);
    check_status("s1");
    check("s1_imem0", tb_imem[0], 32'h00108093);
    check("s1_imem4c", tb_imem[19], 32'h00F12523);
    check_imem("s1_imem");

    // scenario 2: bad checksum, then correct retransmit
    do_start();
    check("s2_done_cleared", 32'(o_done), 32'd0);
    drain("s2_nak", 50);
    rand_data();
    run_block("s2_bad", 8'h01, 8'hFE, 8'h01, 128, 400);
    blk_data = s1_data;
    run_block("s2_good", 8'h01, 8'hFE, 8'h00, 128, 400);
    host_eot();
    drain("s2_eot", 50);
    check_status("s2");
    check("s2_imem0", tb_imem[0], 32'h00108093);
    check_imem("s2_imem");

    // scenario 3: duplicate block, then a block beyond imem
    do_start();
    drain("s3_nak", 50);
    rand_data();
    run_block("s3_blk1", 8'h01, 8'hFE, 8'h00, 128, 400);
    run_block("s3_dup", 8'h01, 8'hFE, 8'h00, 128, 400);
    rand_data();
    run_block("s3_blk2", 8'h02, 8'hFD, 8'h00, 128, 400);
    host_eot();
    drain("s3_eot", 50);
    check_status("s3");
    check_imem("s3_imem");

    // scenario 4: no traffic, retries exhausted
    tx_cyc.delete();
    do_start();
    for (int i = 0; i < MAXR; i++) ref_nak();
    drain("s4", (MAXR + 2) * TO);
    check_status("s4");
    check("s4_tx_count", 32'(tx_cyc.size()), 32'(MAXR + 1));
    span = (tx_cyc.size() > 1) ? tx_cyc[tx_cyc.size()-1] - tx_cyc[0] : 0;
    check("s4_span_ok", 32'((span >= MAXR * TO - 5) && (span <= MAXR * TO + 20)), 32'd1);

    // scenario 5: sequence error, corrupted header, byte timeout
    do_start();
    drain("s5a_nak", 50);
    run_block("s5a_seq", 8'h03, 8'hFC, 8'h00, 128, 100);
    check_status("s5a");
    do_start();
    drain("s5b_nak", 50);
    rand_data();
    run_block("s5b_hdr", 8'h01, 8'h00, 8'h00, 128, 400);
    run_block("s5b_trunc", 8'h01, 8'hFE, 8'h00, 16, TO + 200);
    rand_data();
    run_block("s5b_good", 8'h01, 8'hFE, 8'h00, 128, 400);
    host_eot();
    drain("s5b_eot", 50);
    check_status("s5b");
    check_imem("s5b_imem");

    // scenario 6: reset in the middle of the payload
    do_start();
    drain("s6_nak", 50);
    rand_data();
    wr_cnt = 0;
    rx_q.push_back(B_SOH);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'hFE);
    for (int i = 0; i < 128; i++) rx_q.push_back(blk_data[i]);
    begin
      int n;
      n = 0;
      while (wr_cnt < 3 && n < 200) begin
        step();
        n++;
      end
    end
    check("s6_partial_writes", 32'(wr_cnt >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_outputs", {o_rx_rd, o_tx_wr, o_tx_start, o_imem_we, o_cpu_en, o_busy, o_done, o_error}, 32'd0);
    check("s6_rst_imem_addr", 32'(o_imem_addr), 32'd0);
    rx_q.delete();
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    do_start();
    drain("s6_nak", 50);
    rand_data();
    run_block("s6_blk1", 8'h01, 8'hFE, 8'h00, 128, 400);
    check("s6_first_addr", 32'(first_wr_addr), 32'd0);
    host_eot();
    drain("s6_eot", 50);
    check_status("s6");
    check_imem("s6_imem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
